// File: rtl/stage2_decode_if.sv
// stage2_decode_if: groups the fetch-side, write-back, flush and ID/EX signals of the decode
// stage. The slave modport is the decode stage; the master modport is its environment.
interface stage2_decode_if #(
   parameter int unsigned XLEN = 32
);
   // Fetch side
   logic [XLEN-1:0] If_Pc;
   logic [XLEN-1:0] If_Instruction;
   logic            Hazard_Stall;
   // Execute side
   logic            Flush;
   // Write-back port
   logic            Wb_Reg_Write;
   logic [4:0]      Wb_Rd;
   logic [XLEN-1:0] Wb_Data;
   // ID/EX pipeline register
   logic            Id_Valid;
   logic [XLEN-1:0] Id_Pc;
   logic [XLEN-1:0] Id_Rs1_Data;
   logic [XLEN-1:0] Id_Rs2_Data;
   logic [XLEN-1:0] Id_Imm;
   logic [4:0]      Id_Rs1;
   logic [4:0]      Id_Rs2;
   logic [4:0]      Id_Rd;
   logic [2:0]      Id_Funct3;
   logic            Id_Funct7_B5;
   logic [6:0]      Id_Opcode;
   logic            Id_Reg_Write;
   logic            Id_Mem_Read;
   logic            Id_Mem_Write;
   logic            Id_Is_Branch;
   logic            Id_Is_JAL;
   logic            Id_Is_JAL_R;
   logic            Id_Alu_Src_Imm;
   logic            Id_Illegal;

   modport slave (
      input  If_Pc, If_Instruction, Flush, Wb_Reg_Write, Wb_Rd, Wb_Data,
      output Hazard_Stall, Id_Valid, Id_Pc, Id_Rs1_Data, Id_Rs2_Data, Id_Imm,
             Id_Rs1, Id_Rs2, Id_Rd, Id_Funct3, Id_Funct7_B5, Id_Opcode,
             Id_Reg_Write, Id_Mem_Read, Id_Mem_Write, Id_Is_Branch, Id_Is_JAL,
             Id_Is_JAL_R, Id_Alu_Src_Imm, Id_Illegal
   );

   modport master (
      output If_Pc, If_Instruction, Flush, Wb_Reg_Write, Wb_Rd, Wb_Data,
      input  Hazard_Stall, Id_Valid, Id_Pc, Id_Rs1_Data, Id_Rs2_Data, Id_Imm,
             Id_Rs1, Id_Rs2, Id_Rd, Id_Funct3, Id_Funct7_B5, Id_Opcode,
             Id_Reg_Write, Id_Mem_Read, Id_Mem_Write, Id_Is_Branch, Id_Is_JAL,
             Id_Is_JAL_R, Id_Alu_Src_Imm, Id_Illegal
   );
endinterface

// File: rtl/stage2_decode.sv
// stage2_decode: IF/ID register, 32x32 register file with write-back port, decode and
// immediate generation, load-use hazard detection and the ID/EX register feeding execute.
// Optional feature macro: DECODE_WB_BYPASS_EN -- when defined, the register-file read ports
// forward the write-back data being written in the same cycle.
module stage2_decode (
   input  logic           Clk,
   input  logic           Reset,
   stage2_decode_if.slave bus
);
   localparam int unsigned     XLEN     = 32;
   localparam logic [XLEN-1:0] NOP_INSN = 32'h00000013;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7_b5;
      logic [6:0]      opcode;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            is_branch;
      logic            is_jal;
      logic            is_jalr;
      logic            alu_src_imm;
      logic            illegal;
   } idex_t;

   // IF/ID register
   logic            r_ifid_valid;
   logic [XLEN-1:0] r_ifid_pc;
   logic [XLEN-1:0] r_ifid_insn;

   // Register file and ID/EX register
   logic [XLEN-1:0] r_rf [32];
   idex_t           r_idex;
   idex_t           w_idex;

   // Decode of the IF/ID instruction
   logic [6:0]      w_opcode;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm;
   logic            w_reg_write;
   logic            w_mem_read;
   logic            w_mem_write;
   logic            w_is_branch;
   logic            w_is_jal;
   logic            w_is_jalr;
   logic            w_alu_src_imm;
   logic            w_illegal;
   logic            w_uses_rs2;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;
   logic            w_wb_en;
   logic            w_stall;
   logic            w_bubble;

   assign w_opcode = r_ifid_insn[6:0];
   assign w_rd     = r_ifid_insn[11:7];
   assign w_rs1    = r_ifid_insn[19:15];
   assign w_rs2    = r_ifid_insn[24:20];
   assign w_wb_en  = bus.Wb_Reg_Write & (bus.Wb_Rd != 5'd0);

   // Opcode classification, control generation and immediate formatting
   always_comb begin
      w_imm         = '0;
      w_reg_write   = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_is_branch   = 1'b0;
      w_is_jal      = 1'b0;
      w_is_jalr     = 1'b0;
      w_alu_src_imm = 1'b0;
      w_illegal     = 1'b0;
      w_uses_rs2    = 1'b0;
      case (w_opcode)
         OP_LOAD: begin
            w_imm         = {{20{r_ifid_insn[31]}}, r_ifid_insn[31:20]};
            w_reg_write   = 1'b1;
            w_mem_read    = 1'b1;
            w_alu_src_imm = 1'b1;
         end
         OP_STORE: begin
            w_imm         = {{20{r_ifid_insn[31]}}, r_ifid_insn[31:25], r_ifid_insn[11:7]};
            w_mem_write   = 1'b1;
            w_alu_src_imm = 1'b1;
            w_uses_rs2    = 1'b1;
         end
         OP_BRANCH: begin
            w_imm       = {{20{r_ifid_insn[31]}}, r_ifid_insn[7], r_ifid_insn[30:25],
                           r_ifid_insn[11:8], 1'b0};
            w_is_branch = 1'b1;
            w_uses_rs2  = 1'b1;
         end
         OP_JAL: begin
            w_imm       = {{12{r_ifid_insn[31]}}, r_ifid_insn[19:12], r_ifid_insn[20],
                           r_ifid_insn[30:21], 1'b0};
            w_reg_write = 1'b1;
            w_is_jal    = 1'b1;
         end
         OP_JALR: begin
            w_imm         = {{20{r_ifid_insn[31]}}, r_ifid_insn[31:20]};
            w_reg_write   = 1'b1;
            w_is_jalr     = 1'b1;
            w_alu_src_imm = 1'b1;
         end
         OP_IMM: begin
            w_imm         = {{20{r_ifid_insn[31]}}, r_ifid_insn[31:20]};
            w_reg_write   = 1'b1;
            w_alu_src_imm = 1'b1;
         end
         OP_OP: begin
            w_reg_write = 1'b1;
            w_uses_rs2  = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            w_imm         = {r_ifid_insn[31:12], 12'h000};
            w_reg_write   = 1'b1;
            w_alu_src_imm = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      // Writes to x0 are architecturally discarded, so never request them
      if (w_rd == 5'd0) w_reg_write = 1'b0;
   end

   // Register-file read ports; x0 always reads zero
   always_comb begin
      w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
      w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
`ifdef DECODE_WB_BYPASS_EN
      if (w_wb_en && (bus.Wb_Rd == w_rs1)) w_rs1_data = bus.Wb_Data;
      if (w_wb_en && (bus.Wb_Rd == w_rs2)) w_rs2_data = bus.Wb_Data;
`endif
   end

   // A load in ID/EX whose result feeds the instruction in IF/ID forces one bubble
   assign w_stall  = r_idex.valid & r_idex.mem_read & (r_idex.rd != 5'd0) & r_ifid_valid &
                     ((r_idex.rd == w_rs1) | (w_uses_rs2 & (r_idex.rd == w_rs2)));
   assign w_bubble = bus.Flush | w_stall | ~r_ifid_valid;

   // Next ID/EX contents: decoded instruction, or an all-zero bubble
   always_comb begin
      w_idex = '0;
      if (!w_bubble) begin
         w_idex.valid       = 1'b1;
         w_idex.pc          = r_ifid_pc;
         w_idex.rs1_data    = w_rs1_data;
         w_idex.rs2_data    = w_rs2_data;
         w_idex.imm         = w_imm;
         w_idex.rs1         = w_rs1;
         w_idex.rs2         = w_rs2;
         w_idex.rd          = w_rd;
         w_idex.funct3      = r_ifid_insn[14:12];
         w_idex.funct7_b5   = r_ifid_insn[30];
         w_idex.opcode      = w_opcode;
         w_idex.reg_write   = w_reg_write;
         w_idex.mem_read    = w_mem_read;
         w_idex.mem_write   = w_mem_write;
         w_idex.is_branch   = w_is_branch;
         w_idex.is_jal      = w_is_jal;
         w_idex.is_jalr     = w_is_jalr;
         w_idex.alu_src_imm = w_alu_src_imm;
         w_idex.illegal     = w_illegal;
      end
   end

   // IF/ID register: flush loads an invalid NOP, stall holds, otherwise capture fetch
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= '0;
         r_ifid_insn  <= NOP_INSN;
      end else if (bus.Flush) begin
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= '0;
         r_ifid_insn  <= NOP_INSN;
      end else if (!w_stall) begin
         r_ifid_valid <= 1'b1;
         r_ifid_pc    <= bus.If_Pc;
         r_ifid_insn  <= bus.If_Instruction;
      end
   end

   // Register file write port; independent of stall and flush
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (w_wb_en) begin
         r_rf[bus.Wb_Rd] <= bus.Wb_Data;
      end
   end

   // ID/EX register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) r_idex <= '0;
      else        r_idex <= w_idex;
   end

   assign bus.Hazard_Stall   = w_stall;
   assign bus.Id_Valid       = r_idex.valid;
   assign bus.Id_Pc          = r_idex.pc;
   assign bus.Id_Rs1_Data    = r_idex.rs1_data;
   assign bus.Id_Rs2_Data    = r_idex.rs2_data;
   assign bus.Id_Imm         = r_idex.imm;
   assign bus.Id_Rs1         = r_idex.rs1;
   assign bus.Id_Rs2         = r_idex.rs2;
   assign bus.Id_Rd          = r_idex.rd;
   assign bus.Id_Funct3      = r_idex.funct3;
   assign bus.Id_Funct7_B5   = r_idex.funct7_b5;
   assign bus.Id_Opcode      = r_idex.opcode;
   assign bus.Id_Reg_Write   = r_idex.reg_write;
   assign bus.Id_Mem_Read    = r_idex.mem_read;
   assign bus.Id_Mem_Write   = r_idex.mem_write;
   assign bus.Id_Is_Branch   = r_idex.is_branch;
   assign bus.Id_Is_JAL      = r_idex.is_jal;
   assign bus.Id_Is_JAL_R    = r_idex.is_jalr;
   assign bus.Id_Alu_Src_Imm = r_idex.alu_src_imm;
   assign bus.Id_Illegal     = r_idex.illegal;
endmodule

// File: tb/tb_stage2_decode.sv
// tb_stage2_decode: directed and randomized stimulus for stage2_decode, checked against a
// behavioural model of the two pipeline registers and the register file.
module tb_stage2_decode;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        f7;
      logic [6:0]  op;
      logic        rw, mr, mw, br, jal, jalr, asi, ill;
   } exp_t;

   logic Clk;
   logic Reset;
   stage2_decode_if bus ();

   stage2_decode dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state
   exp_t        m_id;
   logic        m_if_v;
   logic [31:0] m_if_pc, m_if_insn;
   logic [31:0] m_rf [32];
   logic [6:0]  op_tab [10];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_id(input string tag, input exp_t e, input bit full);
      chk({tag, ".valid"}, 32'(bus.Id_Valid), 32'(e.valid));
      chk({tag, ".reg_write"}, 32'(bus.Id_Reg_Write), 32'(e.rw));
      chk({tag, ".mem_read"}, 32'(bus.Id_Mem_Read), 32'(e.mr));
      chk({tag, ".mem_write"}, 32'(bus.Id_Mem_Write), 32'(e.mw));
      chk({tag, ".branch"}, 32'(bus.Id_Is_Branch), 32'(e.br));
      chk({tag, ".jal"}, 32'(bus.Id_Is_JAL), 32'(e.jal));
      chk({tag, ".jalr"}, 32'(bus.Id_Is_JAL_R), 32'(e.jalr));
      chk({tag, ".alu_src_imm"}, 32'(bus.Id_Alu_Src_Imm), 32'(e.asi));
      chk({tag, ".illegal"}, 32'(bus.Id_Illegal), 32'(e.ill));
      if (full || e.valid) begin
         chk({tag, ".pc"}, bus.Id_Pc, e.pc);
         chk({tag, ".rs1_data"}, bus.Id_Rs1_Data, e.rs1d);
         chk({tag, ".rs2_data"}, bus.Id_Rs2_Data, e.rs2d);
         chk({tag, ".imm"}, bus.Id_Imm, e.imm);
         chk({tag, ".rs1"}, 32'(bus.Id_Rs1), 32'(e.rs1));
         chk({tag, ".rs2"}, 32'(bus.Id_Rs2), 32'(e.rs2));
         chk({tag, ".rd"}, 32'(bus.Id_Rd), 32'(e.rd));
         chk({tag, ".funct3"}, 32'(bus.Id_Funct3), 32'(e.f3));
         chk({tag, ".funct7_b5"}, 32'(bus.Id_Funct7_B5), 32'(e.f7));
         chk({tag, ".opcode"}, 32'(bus.Id_Opcode), 32'(e.op));
      end
   endtask

   // Two's-complement interpretation of a w-bit field
   function automatic logic [31:0] sext(input logic [31:0] v, input int w);
      return v[w-1] ? v - (32'd1 << w) : v;
   endfunction

   function automatic exp_t dec(input logic [31:0] pc, input logic [31:0] insn,
                                input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      imm_i = sext(32'(insn[31:20]), 12);
      imm_s = sext(32'({insn[31:25], insn[11:7]}), 12);
      imm_b = sext(32'({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}), 13);
      imm_u = insn & 32'hFFFFF000;
      imm_j = sext(32'({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}), 21);
      e = '0;
      e.valid = 1'b1; e.pc = pc; e.rs1d = d1; e.rs2d = d2;
      e.rs1 = insn[19:15]; e.rs2 = insn[24:20]; e.rd = insn[11:7];
      e.f3 = insn[14:12]; e.f7 = insn[30]; e.op = insn[6:0];
      case (insn[6:0])
         7'h03: begin e.imm = imm_i; e.rw = 1; e.mr = 1; e.asi = 1; end
         7'h23: begin e.imm = imm_s; e.mw = 1; e.asi = 1; end
         7'h63: begin e.imm = imm_b; e.br = 1; end
         7'h6F: begin e.imm = imm_j; e.rw = 1; e.jal = 1; end
         7'h67: begin e.imm = imm_i; e.rw = 1; e.jalr = 1; e.asi = 1; end
         7'h13: begin e.imm = imm_i; e.rw = 1; e.asi = 1; end
         7'h33: begin e.rw = 1; end
         7'h37, 7'h17: begin e.imm = imm_u; e.rw = 1; e.asi = 1; end
         default: e.ill = 1;
      endcase
      if (e.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
      if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (we && wrd != 5'd0 && wrd == idx) return wd;
`endif
      return m_rf[idx];
   endfunction

   function automatic logic model_stall();
      logic [6:0] op;
      logic       rs2_used;
      op = m_if_insn[6:0];
      rs2_used = (op == 7'h23) || (op == 7'h63) || (op == 7'h33);
      return m_id.valid && m_id.mr && (m_id.rd != 5'd0) && m_if_v &&
             ((m_id.rd == m_if_insn[19:15]) || (rs2_used && m_id.rd == m_if_insn[24:20]));
   endfunction

   task automatic model_reset();
      m_id = '0; m_if_v = 1'b0; m_if_pc = '0; m_if_insn = NOP;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
   endtask

   // One clock: drive inputs, check stall, advance DUT and model, check ID/EX
   task automatic cycle(input logic [31:0] pc, input logic [31:0] insn, input logic fl,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
      exp_t nid;
      logic st;
      bus.If_Pc = pc; bus.If_Instruction = insn; bus.Flush = fl;
      bus.Wb_Reg_Write = we; bus.Wb_Rd = wrd; bus.Wb_Data = wd;
      #1;
      st = model_stall();
      chk("hazard_stall", 32'(bus.Hazard_Stall), 32'(st));
      if (fl || st || !m_if_v) nid = '0;
      else nid = dec(m_if_pc, m_if_insn, rd_reg(m_if_insn[19:15], we, wrd, wd),
                     rd_reg(m_if_insn[24:20], we, wrd, wd));
      @(posedge Clk);
      #1;
      m_id = nid;
      if (fl) begin
         m_if_v = 1'b0; m_if_pc = '0; m_if_insn = NOP;
      end else if (!st) begin
         m_if_v = 1'b1; m_if_pc = pc; m_if_insn = insn;
      end
      if (we && wrd != 5'd0) m_rf[wrd] = wd;
      chk_id("idex", m_id, 1'b0);
   endtask

   task automatic nop(input logic [31:0] pc);
      cycle(pc, NOP, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] pc, insn, ins2;
      exp_t zero;
      zero = '0;
      op_tab[0] = 7'h03; op_tab[1] = 7'h23; op_tab[2] = 7'h63; op_tab[3] = 7'h6F;
      op_tab[4] = 7'h67; op_tab[5] = 7'h13; op_tab[6] = 7'h33; op_tab[7] = 7'h37;
      op_tab[8] = 7'h17; op_tab[9] = 7'h0B;
      bus.If_Pc = '0; bus.If_Instruction = NOP; bus.Flush = 1'b0;
      bus.Wb_Reg_Write = 1'b0; bus.Wb_Rd = '0; bus.Wb_Data = '0;

      // Power-on reset
      Reset = 1'b1;
      #1 Reset = 1'b0;
      #2;
      chk_id("reset", zero, 1'b1);
      chk("reset_stall", 32'(bus.Hazard_Stall), 32'd0);
      model_reset();
      @(posedge Clk);
      #3 Reset = 1'b1;

      // Write-back then dependent addi x6,x5,-1
      cycle(32'h0, NOP, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
      cycle(32'h4, 32'hFFF28313, 1'b0, 1'b0, 5'd0, 32'd0);
      nop(32'h8);
      chk("addi_rs1_data", bus.Id_Rs1_Data, 32'hDEADBEEF);
      chk("addi_imm", bus.Id_Imm, 32'hFFFFFFFF);
      chk("addi_rd", 32'(bus.Id_Rd), 32'd6);
      chk("addi_reg_write", 32'(bus.Id_Reg_Write), 32'd1);
      chk("addi_alu_src_imm", 32'(bus.Id_Alu_Src_Imm), 32'd1);

      // Load-use: lw x7,0(x2) ; add x8,x7,x1
      cycle(32'h10, 32'h00012383, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle(32'h14, 32'h00138433, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lu_stall_set", 32'(bus.Hazard_Stall), 32'd1);
      cycle(32'h14, 32'h00138433, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lu_bubble", 32'(bus.Id_Valid), 32'd0);
      chk("lu_stall_clear", 32'(bus.Hazard_Stall), 32'd0);
      nop(32'h18);
      chk("lu_add_valid", 32'(bus.Id_Valid), 32'd1);
      chk("lu_add_rs1", 32'(bus.Id_Rs1), 32'd7);
      chk("lu_add_pc", bus.Id_Pc, 32'h14);

      // Flush together with a load-use stall
      cycle(32'h20, 32'h00012383, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle(32'h24, 32'h00138433, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("fl_stall_set", 32'(bus.Hazard_Stall), 32'd1);
      cycle(32'h24, 32'h00138433, 1'b1, 1'b0, 5'd0, 32'd0);
      chk("fl_bubble", 32'(bus.Id_Valid), 32'd0);
      chk("fl_stall_clear", 32'(bus.Hazard_Stall), 32'd0);
      cycle(32'h40, 32'hFFF28313, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("fl_ifid_invalid", 32'(bus.Id_Valid), 32'd0);
      nop(32'h44);
      chk("fl_resume_valid", 32'(bus.Id_Valid), 32'd1);
      chk("fl_resume_pc", bus.Id_Pc, 32'h40);

      // x0 ignores writes; add x9,x0,x0 ; add x0,x1,x2 never writes
      cycle(32'h48, NOP, 1'b0, 1'b1, 5'd0, 32'h1234);
      cycle(32'h4C, 32'h000004B3, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle(32'h50, 32'h00208033, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("x0_rs1_data", bus.Id_Rs1_Data, 32'd0);
      chk("x0_rs2_data", bus.Id_Rs2_Data, 32'd0);
      nop(32'h54);
      chk("rd0_valid", 32'(bus.Id_Valid), 32'd1);
      chk("rd0_reg_write", 32'(bus.Id_Reg_Write), 32'd0);

      // Same-cycle write-back of x3 while addi x4,x3,0 is decoded
      cycle(32'h58, NOP, 1'b0, 1'b1, 5'd3, 32'h11);
      nop(32'h5C);
      cycle(32'h60, 32'h00018213, 1'b0, 1'b0, 5'd0, 32'd0);
      cycle(32'h64, NOP, 1'b0, 1'b1, 5'd3, 32'h55);
`ifdef DECODE_WB_BYPASS_EN
      chk("wb_same_cycle", bus.Id_Rs1_Data, 32'h55);
`else
      chk("wb_same_cycle", bus.Id_Rs1_Data, 32'h11);
`endif
      nop(32'h68);

      // Randomized traffic; fetch holds its PC while the model predicts a stall
      pc = 32'h100;
      insn = NOP;
      for (int k = 0; k < 300; k++) begin
         if (!model_stall()) begin
            pc = pc + 32'd4;
            insn = $urandom;
            insn[6:0]   = op_tab[$urandom_range(0, 9)];
            insn[11:7]  = 5'($urandom_range(0, 7));
            insn[19:15] = 5'($urandom_range(0, 7));
            insn[24:20] = 5'($urandom_range(0, 7));
         end
         cycle(pc, insn, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 15)), $urandom);
      end

      // Mid-run reset during a load-use stall
      cycle(32'h200, 32'h00012383, 1'b0, 1'b1, 5'd9, 32'hA5A5A5A5);
      cycle(32'h204, 32'h00138433, 1'b0, 1'b1, 5'd31, 32'h5A5A5A5A);
      chk("mid_stall_set", 32'(bus.Hazard_Stall), 32'd1);
      #2 Reset = 1'b0;
      #1;
      chk_id("mid_reset", zero, 1'b1);
      chk("mid_reset_stall", 32'(bus.Hazard_Stall), 32'd0);
      model_reset();
      @(posedge Clk);
      #3 Reset = 1'b1;

      // Every register reads zero after reset: add x1,xi,xi
      for (int i = 1; i < 32; i++) begin
         ins2 = (32'(i) << 20) | (32'(i) << 15) | (32'd1 << 7) | 32'h33;
         cycle(32'h300 + 32'(4 * i), ins2, 1'b0, 1'b0, 5'd0, 32'd0);
         chk("rf_clear_rs1", bus.Id_Rs1_Data, 32'd0);
         chk("rf_clear_rs2", bus.Id_Rs2_Data, 32'd0);
      end
      nop(32'h400);
      chk("rf_clear_last", bus.Id_Rs1_Data, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/stage2_decode.md
# stage2_decode

Second pipeline stage of the RISC-V core, directly downstream of Stage1 (fetch). It holds the IF/ID pipeline register, the 32×32 integer register file with write-back port, instruction decode and immediate generation, load-use hazard detection, and the ID/EX pipeline register that feeds execute. It returns a stall to fetch and accepts a flush from execute on taken branches and jumps.

## Interface
- XLEN, 32, datapath width
- NOP_INSN, 32'h00000013, instruction word held in IF/ID after reset or flush (addi x0,x0,0)

- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- If_Pc  in  32  PC of fetched instruction (Stage1 Pc_Out)
- If_Instruction  in  32  fetched instruction word
- Flush  in  1  taken branch/JAL/JALR resolved in execute
- Wb_Reg_Write  in  1  write-back enable
- Wb_Rd  in  5  write-back destination
- Wb_Data  in  32  write-back data
- Hazard_Stall  out  1  combinational; Stage1 must hold PC while high
- Id_Valid  out  1  ID/EX slot holds a real instruction
- Id_Pc  out  32  PC of instruction in ID/EX
- Id_Rs1_Data, Id_Rs2_Data  out  32 each  register operands
- Id_Imm  out  32  sign-extended immediate
- Id_Rs1, Id_Rs2, Id_Rd  out  5 each  register indices
- Id_Funct3  out  3;  Id_Funct7_B5  out  1  ALU qualifiers
- Id_Opcode  out  7  opcode field
- Id_Reg_Write, Id_Mem_Read, Id_Mem_Write, Id_Is_Branch, Id_Is_JAL, Id_Is_JAL_R, Id_Alu_Src_Imm  out  1 each  controls
- Id_Illegal  out  1  unsupported opcode in ID/EX

## Operation
- IF/ID register: {valid, pc, instruction}. Loads If_* with valid=1 each edge unless stalled or flushed.
- Decode (combinational from IF/ID): opcode classes LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111. Anything else: Id_Illegal=1, all write/memory/branch controls 0.
- Immediates: I (LOAD, OP-IMM, JALR), S, B (bit0=0), U (low 12 bits 0), J (bit0=0); all sign-extended from bit 31; R-type Imm=0.
- Rs1/Rs2 indices always from bits 19:15 / 24:20; Rd from 11:7. Id_Reg_Write forced 0 when Rd=0.
- Register file: 32×32, x0 reads 0 and ignores writes; write on rising edge when Wb_Reg_Write and Wb_Rd≠0.
- Load-use hazard: Hazard_Stall = Id_Valid & Id_Mem_Read & Id_Rd≠0 & IF/ID valid & (Id_Rd==rs1 of IF/ID, or Id_Rd==rs2 of IF/ID for STORE/BRANCH/OP).
- On stall: IF/ID holds, ID/EX loads bubble (Id_Valid=0, all controls 0).
- On Flush: IF/ID loads NOP_INSN with valid=0; ID/EX loads bubble. Flush overrides stall; Hazard_Stall is still computed but ignored internally.
- Bubble/invalid IF/ID: ID/EX receives Id_Valid=0 and all controls 0; data fields don't-care but driven deterministically.

## Timing
- Reset (asserted low, async): IF/ID = {0, 0, NOP_INSN}; all ID/EX outputs 0; all 32 registers 0; Hazard_Stall 0.
- Latency: If_* sampled at edge N appears on Id_* after edge N+1.
- Write-back in the same cycle a decode reads the same register: see Configuration.
- Write-back is unaffected by stall and flush.
- Reset deasserting mid-cycle: first capture at next rising edge.

## Configuration
- DECODE_WB_BYPASS_EN defined: read ports forward Wb_Data when Wb_Reg_Write & Wb_Rd≠0 & Wb_Rd matches the read index; decode sees the value being written this cycle.
- Undefined: read ports return the array contents; a same-cycle write is visible only from the next cycle. Writeback must then be separated by one extra cycle from the dependent decode.

## Test plan
- Reset low mid-run -> all Id_* 0, Hazard_Stall 0 immediately; x1..x31 read 0 afterward.
- Write x5=32'hDEADBEEF, then decode addi x6,x5,-1 (32'hFFF28313) -> Id_Rs1_Data=DEADBEEF, Id_Imm=FFFFFFFF, Id_Rd=6, Id_Reg_Write=1, Id_Alu_Src_Imm=1.
- lw x7,0(x2) followed by add x8,x7,x1 -> Hazard_Stall=1 for one cycle, one bubble (Id_Valid=0), then add appears with Rs1=7.
- Flush asserted together with a load-use stall -> both stages bubbled, IF/ID holds NOP_INSN valid=0, next fetched instruction proceeds.
- Write x0=32'h1234 then add x9,x0,x0 -> Id_Rs1_Data=Id_Rs2_Data=0; Id_Reg_Write=0 for any Rd=0.
- Same-cycle write x3=32'h55 with decode of x3 -> 32'h55 with DECODE_WB_BYPASS_EN, old value without.
